// File: rtl/result_pkg.sv
// Shared types and defaults for draining the point-in-triangle result memory.
// Imported by the reader, the classifier bench and the file-writer model.
package result_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int PACK_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/result_reader_bit_packer.sv
// PACK_W-bit pack register: clear, write one bit at the running index,
// and flag when the next write fills the top bit.
module bit_packer
  import result_pkg::*;
#(
  parameter int PACK_W = PACK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_bit,
  output logic [PACK_W-1:0] data,
  output logic              full
);

  localparam int IDX_W = $clog2(PACK_W);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      idx  <= '0;
    end else if (clr) begin
      data <= '0;
      idx  <= '0;
    end else if (wr_en) begin
      data[idx] <= wr_bit;
      idx       <= idx + IDX_W'(1);
    end
  end

  // "full" means the write happening this cycle lands in the top bit.
  assign full = (idx == IDX_W'(PACK_W - 1));

endmodule

// File: rtl/result_reader.sv
// Drains the 1-bit result memory from address 0 to count-1 and streams the
// bits LSB-first as PACK_W-bit words over a valid/ready interface.
module result_reader
  import result_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PACK_W = PACK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_data,
  output logic [PACK_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt_r;
  logic [PACK_W-1:0] pk_data;
  logic              pk_full;
  logic              pk_clr;
  logic              start_ok;
  logic              last_addr;
  logic              none_left;
  logic              handshake;

  assign start_ok  = (state == IDLE) && start;
  assign last_addr = (mem_addr == (cnt_r - ADDR_W'(1)));
  // mem_addr already points past the final read once every address is consumed.
  assign none_left = (mem_addr == cnt_r);
  assign handshake = (state == EMIT) && out_ready;
  assign pk_clr    = start_ok || (handshake && !none_left);

  bit_packer #(
    .PACK_W(PACK_W)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pk_clr),
    .wr_en (state == READ),
    .wr_bit(mem_data),
    .data  (pk_data),
    .full  (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_r    <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        cnt_r    <= count;
        mem_addr <= '0;
      end else if (state == READ) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : READ;
      READ:    if (pk_full || last_addr) state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = none_left ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from the state register; the word is only shown while offered.
  assign mem_rd    = (state == READ);
  assign out_valid = (state == EMIT);
  assign out_data  = (state == EMIT) ? pk_data : '0;
  assign out_last  = (state == EMIT) && none_left;
  assign busy      = (state == READ) || (state == EMIT);
  assign done      = (state == DONE);

endmodule
